checkout: RTL

//  Exit-side counterpart of the parking check-in register bank. On a checkout request for a

---
 rtl/checkout_if.sv | 32 +++
 rtl/checkout.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/checkout_if.sv
// Checkout bus: request/selector/slot inputs from the exit side, result outputs to the fee display.
interface checkout_if #(
    parameter int unsigned FEE_W = 12
);
    logic             req;
    logic [3:0]       selector;
    logic [10:0]      timer;
    logic [10:0]      p1;
    logic [10:0]      p2;
    logic [10:0]      p3;
    logic [10:0]      p4;
    logic [10:0]      p5;
    logic [10:0]      p6;
    logic [5:0]       occupied;
    logic             busy;
    logic             done;
    logic             err;
    logic [5:0]       slot_release;
    logic [10:0]      duration;
    logic [5:0]       units;
    logic [FEE_W-1:0] fee;

    modport master (
        output req, selector, timer, p1, p2, p3, p4, p5, p6, occupied,
        input  busy, done, err, slot_release, duration, units, fee
    );

    modport slave (
        input  req, selector, timer, p1, p2, p3, p4, p5, p6, occupied,
        output busy, done, err, slot_release, duration, units, fee
    );
endinterface

// File: rtl/checkout.sv
// Parking exit checkout: elapsed time for a slot, round-up billing with grace period,
// saturating fee, and a one-hot release pulse for the freed slot.
module checkout #(
    parameter int unsigned UNIT_TICKS  = 60,
    parameter int unsigned RATE        = 20,
    parameter int unsigned GRACE_TICKS = 15,
    parameter int unsigned FEE_W       = 12
) (
    input logic       clk,
    input logic       rst,
    checkout_if.slave bus
);

    localparam logic [FEE_W-1:0] FEE_MAX   = '1;
    localparam logic [10:0]      UNIT_STEP = 11'(UNIT_TICKS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sel_q, sel_d;
    logic [10:0]      tlat_q, tlat_d;
    logic [10:0]      dur_q, dur_d;
    logic [10:0]      rem_q, rem_d;
    logic [5:0]       units_q, units_d;
    logic [FEE_W-1:0] fee_q, fee_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [5:0]       rel_q, rel_d;

    logic [5:0]       sel_onehot;
    logic [10:0]      p_sel;
    logic             slot_ok;
    logic [10:0]      diff;
    logic [31:0]      fee_sum;

    // Decode latched selector into a one-hot slot mask and pick that slot's check-in time
    always_comb begin
        sel_onehot = '0;
        p_sel      = '0;
        case (sel_q)
            4'd1: begin sel_onehot = 6'b000001; p_sel = bus.p1; end
            4'd2: begin sel_onehot = 6'b000010; p_sel = bus.p2; end
            4'd3: begin sel_onehot = 6'b000100; p_sel = bus.p3; end
            4'd4: begin sel_onehot = 6'b001000; p_sel = bus.p4; end
            4'd5: begin sel_onehot = 6'b010000; p_sel = bus.p5; end
            4'd6: begin sel_onehot = 6'b100000; p_sel = bus.p6; end
            default: begin sel_onehot = '0; p_sel = '0; end
        endcase
        // an invalid selector decodes to an empty mask, so it can never match occupied
        slot_ok = |(sel_onehot & bus.occupied);
        diff    = tlat_q - p_sel;
        fee_sum = 32'(fee_q) + RATE;
    end

    // Next-state and next-output computation for the checkout sequencer
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tlat_d  = tlat_q;
        dur_d   = dur_q;
        rem_d   = rem_q;
        units_d = units_q;
        fee_d   = fee_q;
        err_d   = err_q;
        done_d  = 1'b0;
        rel_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    sel_d   = bus.selector;
                    tlat_d  = bus.timer;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                units_d = '0;
                fee_d   = '0;
                if (!slot_ok) begin
                    err_d   = 1'b1;
                    dur_d   = '0;
                    rem_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    err_d = 1'b0;
                    dur_d = diff;
                    rem_d = diff;
                    if (32'(diff) <= GRACE_TICKS) begin
                        done_d  = 1'b1;
                        rel_d   = sel_onehot;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                units_d = units_q + 6'd1;
                fee_d   = (fee_sum > 32'(FEE_MAX)) ? FEE_MAX : fee_sum[FEE_W-1:0];
                if (32'(rem_q) <= UNIT_TICKS) begin
                    done_d  = 1'b1;
                    rel_d   = sel_onehot;
                    state_d = S_DONE;
                end else begin
                    rem_d = rem_q - UNIT_STEP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            tlat_q  <= '0;
            dur_q   <= '0;
            rem_q   <= '0;
            units_q <= '0;
            fee_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tlat_q  <= tlat_d;
            dur_q   <= dur_d;
            rem_q   <= rem_d;
            units_q <= units_d;
            fee_q   <= fee_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rel_q   <= rel_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.slot_release = rel_q;
    assign bus.duration     = dur_q;
    assign bus.units        = units_q;
    assign bus.fee          = fee_q;

endmodule
